// File: rtl/arm_seq_pkg.sv
// Shared types and encodings for the ARM multicycle control sequencer.
// Define ARM_SEQ_REGSHIFT_EN to include the SHIFT state for register-shifted-register DP.
package arm_seq_pkg;

`ifdef ARM_SEQ_REGSHIFT_EN
  typedef enum logic [2:0] {S_DECODE, S_SHIFT, S_EXEC, S_MEM, S_WB} state_t;
`else
  typedef enum logic [2:0] {S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
`endif

  typedef enum logic [1:0] {
    CLS_DP     = 2'b00,
    CLS_MEM    = 2'b01,
    CLS_BRANCH = 2'b10,
    CLS_UNDEF  = 2'b11
  } instr_class_t;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0010;

  localparam logic [1:0] IMM_DP     = 2'b00;
  localparam logic [1:0] IMM_MEM    = 2'b01;
  localparam logic [1:0] IMM_BRANCH = 2'b10;

  // Field order matches the top-level output concatenation.
  typedef struct packed {
    logic [1:0] reg_src;
    logic [1:0] imm_src;
    logic [3:0] alu_control;
    logic       reg_write;
    logic       alu_src;
    logic       mem_to_reg;
    logic       pc_src;
    logic       link_select;
    logic       shift_sel;
    logic       pc_write;
    logic       mem_req;
    logic       mem_write;
    logic       undef;
  } ctrl_t;

  function automatic logic [3:0] mem_alu_op(input logic up);
    return up ? ALU_ADD : ALU_SUB;
  endfunction

endpackage

// File: rtl/arm_seq_ctrl_cond_check.sv
// Combinational ARM condition-code evaluator: 4-bit cond plus NZCV gives pass.
// Behaviour is identical with or without ARM_SEQ_REGSHIFT_EN.
module cond_check
  import arm_seq_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign {n, z, c, v} = flags;

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/arm_seq_ctrl.sv
// Multicycle ARM control sequencer: decode, condition check, NZCV register and memory stall.
// Define ARM_SEQ_REGSHIFT_EN to execute register-shifted-register DP via a SHIFT state.
module arm_seq_ctrl
  import arm_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  input  logic        MemReady,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ImmSrc,
  output logic [3:0]  ALUControl,
  output logic        RegWrite,
  output logic        ALUSrc,
  output logic        MemtoReg,
  output logic        PCSrc,
  output logic        linkSelect,
  output logic        ShiftSel,
  output logic        storedCarry,
  output logic        PCWrite,
  output logic        MemReq,
  output logic        MemWrite,
  output logic        Undef
);

  state_t       state, state_next;
  instr_class_t cls;
  ctrl_t        ctrl;
  logic [3:0]   flags;
  logic         flags_load;
  logic         cond_pass;
  logic         imm, link, up, load, set_flags, cmp_cmd, rd_pc;
  logic         reg_shift, undef_instr;
  logic         unused_bits;

  assign cls       = instr_class_t'(Instr[27:26]);
  assign imm       = Instr[25];
  assign link      = Instr[24];
  assign up        = Instr[23];
  assign load      = Instr[20];
  assign set_flags = Instr[20];
  assign cmp_cmd   = (Instr[24:23] == 2'b10);
  assign rd_pc     = (Instr[15:12] == 4'hF);
  assign reg_shift = (cls == CLS_DP) && !imm && Instr[4];

`ifdef ARM_SEQ_REGSHIFT_EN
  assign undef_instr = (cls == CLS_UNDEF);
`else
  assign undef_instr = (cls == CLS_UNDEF) || reg_shift;
`endif

  assign unused_bits = ^{Instr[19:16], Instr[11:5], Instr[3:0]};

  cond_check u_cond_check (
    .cond  (Instr[31:28]),
    .flags (flags),
    .pass  (cond_pass)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_DECODE;
      flags <= '0;
    end else begin
      state <= state_next;
      if (flags_load) flags <= ALUFlags;
    end
  end

  always_comb begin
    state_next = state;
    ctrl       = '0;
    flags_load = 1'b0;
    case (state)
      S_DECODE: begin
        if (undef_instr || !cond_pass) begin
          ctrl.pc_write = 1'b1;
          ctrl.undef    = undef_instr;
        end
`ifdef ARM_SEQ_REGSHIFT_EN
        else if (reg_shift) state_next = S_SHIFT;
`endif
        else state_next = S_EXEC;
      end
`ifdef ARM_SEQ_REGSHIFT_EN
      S_SHIFT: begin
        ctrl.shift_sel = 1'b1;
        state_next     = S_EXEC;
      end
`endif
      S_EXEC: begin
        case (cls)
          CLS_DP: begin
            ctrl.alu_control = Instr[24:21];
            ctrl.alu_src     = imm;
            ctrl.imm_src     = IMM_DP;
            ctrl.reg_write   = !cmp_cmd;
            ctrl.pc_src      = !cmp_cmd && rd_pc;
            ctrl.pc_write    = 1'b1;
            flags_load       = set_flags || cmp_cmd;
            state_next       = S_DECODE;
          end
          CLS_MEM: begin
            ctrl.alu_src     = 1'b1;
            ctrl.imm_src     = IMM_MEM;
            ctrl.alu_control = mem_alu_op(up);
            state_next       = S_MEM;
          end
          CLS_BRANCH: begin
            ctrl.reg_src[0]  = 1'b1;
            ctrl.imm_src     = IMM_BRANCH;
            ctrl.alu_src     = 1'b1;
            ctrl.alu_control = ALU_ADD;
            ctrl.pc_src      = 1'b1;
            ctrl.link_select = link;
            ctrl.reg_write   = link;
            ctrl.pc_write    = 1'b1;
            state_next       = S_DECODE;
          end
          default: state_next = S_DECODE;
        endcase
      end
      // Address controls stay put for the whole stall so the memory sees a stable request.
      S_MEM: begin
        ctrl.alu_src     = 1'b1;
        ctrl.imm_src     = IMM_MEM;
        ctrl.alu_control = mem_alu_op(up);
        ctrl.mem_req     = 1'b1;
        ctrl.mem_write   = !load;
        ctrl.reg_src[1]  = !load;
        if (MemReady) begin
          if (load) begin
            state_next = S_WB;
          end else begin
            ctrl.pc_write = 1'b1;
            state_next    = S_DECODE;
          end
        end
      end
      S_WB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.pc_src     = rd_pc;
        ctrl.pc_write   = 1'b1;
        state_next      = S_DECODE;
      end
      default: state_next = S_DECODE;
    endcase
  end

  // Gating with reset makes every control drop the instant reset asserts, even mid-MEM.
  assign {RegSrc, ImmSrc, ALUControl, RegWrite, ALUSrc, MemtoReg, PCSrc,
          linkSelect, ShiftSel, PCWrite, MemReq, MemWrite, Undef} = reset ? ctrl : '0;

  assign storedCarry = flags[1];

endmodule
